aes_core_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one AES_top encryption core between two requesters.
- Accepts a plaintext/key job from a requester through a valid/ready handshake, then drives the core enable, data and key.
- Waits for the core's valid output, or for a timeout, and returns the result with the requester ID through a response handshake.
- Sits between the system request fabric and AES_top. It is the only driver of the core's AES_en, AES_data_in and AES_key_in.

---
 rtl/aes_core_arbiter.sv | 79 +++++++
 tb/tb_aes_core_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sequencer sharing one AES_top core between two requesters
// Ports: AES_clk/AES_rst clock and sync active-high reset; req0_*/req1_* job valid/ready
// with plaintext and key; rsp_* result handshake with id, ciphertext and timeout flag;
// core_* drive and observe AES_top; busy is high whenever the sequencer is not idle.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC = 2,
  parameter int CNT_W = 8
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic last_grant, grant, accept, timeout_hit;
  always_comb begin
    grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) & req0_valid & ~grant;
    req1_ready = (state == IDLE) & req1_valid & grant;
    accept = req0_ready | req1_ready;
    timeout_hit = cnt == CNT_W'(TIMEOUT_CYC - 1);
    core_en = state == RUN;
    rsp_valid = state == RESP;
    busy = state != IDLE;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = (core_data_out_valid | timeout_hit) ? RESP : RUN;
      RESP:    state_nxt = rsp_ready ? GAP : RESP;
      default: state_nxt = (cnt == CNT_W'(GAP_CYC - 1)) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      core_data_in <= '0;
      core_key_in <= '0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == RUN || state == GAP) ? cnt + 1'b1 : '0;
      if (accept) begin
        core_data_in <= grant ? req1_data : req0_data;
        core_key_in <= grant ? req1_key : req0_key;
        rsp_id <= grant;
        last_grant <= grant;
      end
      // a core result landing on the timeout cycle still counts as a result
      if (state == RUN && state_nxt == RESP) begin
        rsp_data <= core_data_out_valid ? core_data_out : '0;
        rsp_timeout <= ~core_data_out_valid;
      end
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: scoreboard bench for aes_core_arbiter with a stub AES core
module tb_aes_core_arbiter;
  localparam int TO = 64;
  localparam int GAP = 2;
  localparam logic [127:0] D0 = 128'h000000d1_00000000_00000000_00000000;
  localparam logic [127:0] K0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] D1 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] K1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] D2 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] K2 = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
  typedef struct {
    logic v0; logic v1;
    logic [127:0] d0; logic [127:0] k0; logic [127:0] d1; logic [127:0] k1;
    int lat; logic exp_id;
  } vec_t;
  typedef struct {
    logic id; logic [127:0] dat; logic [127:0] key; logic [127:0] res;
    logic to; int acc; int dly;
  } exp_t;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0, spur = 0;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_timeout, core_en, busy, core_data_out_valid;
  logic [127:0] rsp_data, core_data_in, core_key_in, core_data_out;
  int total = 0, bad = 0, cyc = 0, lat = 10, en_cnt = 0;
  exp_t q[$];
  int acc_log[$];
  logic gnt_log[$];

  aes_core_arbiter #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP), .CNT_W(8)) dut (
    .AES_clk(clk), .AES_rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .core_en(core_en), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // stub core: result is data^key on the lat-th cycle of core_en (lat 0 = never)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    en_cnt <= core_en ? en_cnt + 1 : 0;
  end
  assign core_data_out_valid = spur | (core_en && lat > 0 && en_cnt == lat - 1);
  assign core_data_out = core_data_in ^ core_key_in;

  task automatic report(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    report(name, act, exp);
  endtask
  task automatic chkb(input string name, input logic act, input logic exp);
    report(name, {127'b0, act}, {127'b0, exp});
  endtask
  task automatic chki(input string name, input int act, input int exp);
    report(name, {96'b0, act}, {96'b0, exp});
  endtask

  // monitor and scoreboard
  initial begin
    logic acc_prev, rv_prev, hit, acc;
    exp_t e;
    acc_prev = 0;
    rv_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        acc_prev = 0;
        rv_prev = 0;
      end else begin
        chkb("one_ready", req0_ready & req1_ready, 1'b0);
        if (acc_prev) chkb("core_en_after_accept", core_en, 1'b1);
        if (core_en && q.size() != 0) begin
          chk("core_data_in", core_data_in, q[0].dat);
          chk("core_key_in", core_key_in, q[0].key);
        end
        if (rsp_valid) begin
          chkb("core_en_low_in_resp", core_en, 1'b0);
          if (q.size() == 0) chkb("rsp_without_job", rsp_valid, 1'b0);
          else begin
            if (!rv_prev) chki("rsp_latency", cyc - q[0].acc, q[0].dly);
            chkb("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].res);
            chkb("rsp_timeout", rsp_timeout, q[0].to);
            if (rsp_ready) void'(q.pop_front());
          end
        end
        rv_prev = rsp_valid & ~rsp_ready;
        acc = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (acc) begin
          e.id = req1_ready;
          e.dat = e.id ? req1_data : req0_data;
          e.key = e.id ? req1_key : req0_key;
          hit = lat >= 1 && lat <= TO;
          e.res = hit ? e.dat ^ e.key : '0;
          e.to = !hit;
          e.acc = cyc;
          e.dly = hit ? lat + 1 : TO + 1;
          q.push_back(e);
          acc_log.push_back(cyc);
          gnt_log.push_back(e.id);
        end
        acc_prev = acc;
      end
    end
  end

  task automatic wait_accept(input int n0);
    int t = 0;
    while (gnt_log.size() == n0 && t < 100) begin @(posedge clk); #1; t++; end
    chki("accept_seen", gnt_log.size(), n0 + 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || q.size() != 0) && t < 400) begin @(posedge clk); #1; t++; end
    chkb("idle_reached", busy, 1'b0);
    chki("scoreboard_drained", q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n0 = gnt_log.size();
    lat = v.lat;
    req0_data = v.d0; req0_key = v.k0; req1_data = v.d1; req1_key = v.k1;
    req0_valid = v.v0; req1_valid = v.v1;
    wait_accept(n0);
    req0_valid = 0; req1_valid = 0;
    if (gnt_log.size() > n0) chkb("grant_id", gnt_log[n0], v.exp_id);
    wait_idle();
  endtask

  task automatic chk_reset_outputs();
    chki("reset_flags", int'({rsp_valid, rsp_id, rsp_timeout, core_en, busy, req0_ready, req1_ready}), 0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_core_data", core_data_in, '0);
    chk("reset_core_key", core_key_in, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int n0, t;
    logic [127:0] held;
    vt[0] = '{1'b1, 1'b0, D0, K0, D1, K1, 10, 1'b0};
    vt[1] = '{1'b1, 1'b1, D2, K2, D1, K1, 5, 1'b1};
    vt[2] = '{1'b1, 1'b1, D1, K0, D2, K1, 3, 1'b0};
    vt[3] = '{1'b0, 1'b1, D0, K0, D2, K2, 1, 1'b1};
    vt[4] = '{1'b1, 1'b0, D2, K1, D0, K0, 0, 1'b0};
    vt[5] = '{1'b0, 1'b1, D0, K0, D1, K2, 64, 1'b1};
    vt[6] = '{1'b1, 1'b1, D1, K2, D0, K1, 63, 1'b0};
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 0;
    foreach (vt[i]) run_vec(vt[i]);

    // backpressure: response must hold while rsp_ready is low
    lat = 10; rsp_ready = 0;
    req0_data = D2; req0_key = K2; req1_data = D1; req1_key = K1;
    n0 = gnt_log.size();
    req0_valid = 1;
    wait_accept(n0);
    req0_valid = 0; req1_valid = 1;
    t = 0;
    while (!rsp_valid && t < 100) begin @(posedge clk); #1; t++; end
    chkb("bp_rsp_seen", rsp_valid, 1'b1);
    held = rsp_data;
    repeat (20) begin
      @(negedge clk);
      chkb("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, held);
      chkb("bp_no_ready", req0_ready | req1_ready, 1'b0);
      chkb("bp_core_en", core_en, 1'b0);
    end
    @(posedge clk); #1;
    req1_valid = 0; rsp_ready = 1;
    wait_idle();

    // spurious core valid during GAP must not produce a response
    lat = 3;
    n0 = gnt_log.size();
    req1_valid = 1;
    wait_accept(n0);
    req1_valid = 0;
    t = 0;
    while (!(busy && !core_en && !rsp_valid) && t < 100) begin @(posedge clk); #1; t++; end
    chkb("gap_reached", busy, 1'b1);
    spur = 1;
    @(posedge clk); #1;
    spur = 0;
    chkb("gap_spur_ignored", rsp_valid, 1'b0);
    chkb("gap_core_en", core_en, 1'b0);
    wait_idle();

    // contention from reset release: alternating grants, fixed spacing
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    lat = 10;
    n0 = gnt_log.size();
    req0_data = D0; req0_key = K0; req1_data = D1; req1_key = K1;
    req0_valid = 1; req1_valid = 1;
    t = 0;
    while (gnt_log.size() < n0 + 4 && t < 200) begin @(posedge clk); #1; t++; end
    req0_valid = 0; req1_valid = 0;
    chki("contention_count", gnt_log.size(), n0 + 4);
    for (int i = 0; i < 4 && n0 + i < gnt_log.size(); i++) begin
      chkb("contention_grant", gnt_log[n0 + i], i[0]);
      if (i > 0) chki("contention_spacing", acc_log[n0 + i] - acc_log[n0 + i - 1], 10 + 2 + GAP);
    end
    wait_idle();

    // reset during RUN cycle 5 drops the job
    lat = 20;
    req0_data = D1; req0_key = K0;
    n0 = gnt_log.size();
    req0_valid = 1;
    wait_accept(n0);
    req0_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    chkb("mid_run_core_en", core_en, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset_outputs();
    lat = 10;
    n0 = gnt_log.size();
    req0_data = D2; req0_key = K2; req1_data = D0; req1_key = K1;
    req0_valid = 1; req1_valid = 1;
    wait_accept(n0);
    req0_valid = 0; req1_valid = 0;
    if (gnt_log.size() > n0) chkb("post_reset_grant", gnt_log[n0], 1'b0);
    wait_idle();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
